// File: rtl/axi_10g_ethernet_0_checksum_stream.sv
//------------------------------------------------------------------------------
// axi_10g_ethernet_0_checksum_stream
//
// Purpose:
//   Passive monitor on an AXI-Stream datapath. Computes the 16-bit Internet
//   (one's-complement) checksum of every tlast-delimited frame. Each result
//   is pushed to a downstream FIFO through a din/wr_en/full write port. A
//   small result queue absorbs back-pressure, and any result that cannot be
//   queued is counted and flagged.
//
// Parameters:
//   DATA_WIDTH   - stream data width in bits (64 or 128)
//   RESULT_DEPTH - result queue entries (power of 2, >= 2)
//   INVERT       - 1: output ~folded sum, 0: output raw folded sum
//
// Ports:
//   s_aclk, s_areset       - clock, asynchronous active-high reset
//   s_axis_tvalid/tready   - beat qualifier (monitor only, never driven)
//   s_axis_tdata/tkeep     - beat payload, byte 0 = tdata[7:0] first on wire
//   s_axis_tlast           - end of frame
//   cfg_seed               - initial partial sum, sampled on a frame's 1st beat
//   din, wr_en, full       - downstream FIFO write port
//   overflow               - sticky "result dropped" flag
//   drop_count             - saturating count of dropped results
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module axi_10g_ethernet_0_checksum_stream #(
    parameter int DATA_WIDTH   = 64,
    parameter int RESULT_DEPTH = 4,
    parameter bit INVERT       = 1'b1
) (
    input  logic                    s_aclk,
    input  logic                    s_areset,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic [15:0]             cfg_seed,
    output logic [15:0]             din,
    output logic                    wr_en,
    input  logic                    full,
    output logic                    overflow,
    output logic [15:0]             drop_count
);

    localparam int NUM_WORDS = DATA_WIDTH / 16;
    localparam int PTR_W     = $clog2(RESULT_DEPTH);
    localparam logic [PTR_W:0] QUEUE_MAX = (PTR_W+1)'(RESULT_DEPTH);

    // Sum of the 16-bit words of one beat. Word k is {byte 2k, byte 2k+1};
    // disabled bytes contribute zero, which also yields {b, 8'h00} for an
    // odd trailing byte b.
    function automatic logic [31:0] f_beat_sum(
        input logic [DATA_WIDTH-1:0]   data,
        input logic [DATA_WIDTH/8-1:0] keep
    );
        logic [31:0] sum;
        logic [7:0]  hi;
        logic [7:0]  lo;
        sum = 32'h0000_0000;
        for (int k = 0; k < NUM_WORDS; k++) begin
            hi  = keep[2*k]   ? data[16*k +: 8]   : 8'h00;
            lo  = keep[2*k+1] ? data[16*k+8 +: 8] : 8'h00;
            sum = sum + {16'h0000, hi, lo};
        end
        return sum;
    endfunction

    //--------------------------------------------------------------------------
    // Stage 0: per-frame accumulation
    //--------------------------------------------------------------------------
    logic        w_beat;
    logic [31:0] w_beat_sum;
    logic [31:0] w_acc_base;
    logic [31:0] w_acc_next;

    logic        r_first;      // next accepted beat opens a new frame
    logic [31:0] r_acc;        // running sum of the frame in progress
    logic        r_p0_vld;
    logic [31:0] r_p0_sum;     // final 32-bit frame sum

    // A 32-bit accumulator cannot overflow for any realistic frame: a 9 KB
    // jumbo frame adds at most ~4.6k words of 16'hFFFF.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no
        // latch is inferred.
        w_beat     = s_axis_tvalid & s_axis_tready;
        w_beat_sum = f_beat_sum(s_axis_tdata, s_axis_tkeep);
        w_acc_base = r_first ? {16'h0000, cfg_seed} : r_acc;
        w_acc_next = w_acc_base + w_beat_sum;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_first  <= 1'b1;
            r_acc    <= 32'h0000_0000;
            r_p0_vld <= 1'b0;
            r_p0_sum <= 32'h0000_0000;
        end else begin
            r_p0_vld <= w_beat & s_axis_tlast;
            if (w_beat) begin
                r_first <= s_axis_tlast;
                if (s_axis_tlast) begin
                    r_p0_sum <= w_acc_next;
                    r_acc    <= 32'h0000_0000;
                end else begin
                    r_acc    <= w_acc_next;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Fold pipeline: two end-around-carry folds, then optional inversion.
    // After the first fold the value is at most 17'h1FFFE, so the second
    // 16-bit fold cannot carry out again.
    //--------------------------------------------------------------------------
    logic        r_p1_vld;
    logic [31:0] r_p1_s1;
    logic [15:0] w_s2;
    logic [15:0] w_result;
    logic        r_p2_vld;
    logic [15:0] r_p2_res;

    always_comb begin
        w_s2     = r_p1_s1[31:16] + r_p1_s1[15:0];
        w_result = INVERT ? ~w_s2 : w_s2;
    end

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_p1_vld <= 1'b0;
            r_p1_s1  <= 32'h0000_0000;
            r_p2_vld <= 1'b0;
            r_p2_res <= 16'h0000;
        end else begin
            r_p1_vld <= r_p0_vld;
            if (r_p0_vld) begin
                r_p1_s1 <= {16'h0000, r_p0_sum[31:16]} + {16'h0000, r_p0_sum[15:0]};
            end
            r_p2_vld <= r_p1_vld;
            if (r_p1_vld) begin
                r_p2_res <= w_result;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Result queue and FIFO write port
    //--------------------------------------------------------------------------
    logic [15:0]      r_mem [RESULT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_q_full;

    logic [15:0]      r_din;
    logic             r_wr_en;
    logic             r_overflow;
    logic [15:0]      r_drop_count;

    // A pop frees a slot in the same cycle, so a result arriving while the
    // queue is full is still accepted whenever the FIFO is draining.
    always_comb begin
        w_q_full = (r_count == QUEUE_MAX);
        w_pop    = (r_count != '0) && !full;
        w_push   = r_p2_vld && (!w_q_full || w_pop);
        w_drop   = r_p2_vld && w_q_full && !w_pop;
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // it has been written, and the pointers/count are what reset clears.
    always_ff @(posedge s_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_p2_res;
        end
    end

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // din is registered and holds its last value while the FIFO is full.
    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            r_din        <= 16'h0000;
            r_wr_en      <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'h0000;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_din <= r_mem[r_rd_ptr];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'h0001;
                end
            end
        end
    end

    assign din        = r_din;
    assign wr_en      = r_wr_en;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_axi_10g_ethernet_0_checksum_stream.sv
//------------------------------------------------------------------------------
// tb_axi_10g_ethernet_0_checksum_stream
//
// Purpose:
//   Directed self-checking bench. Two instances share one stimulus stream:
//   u_dut_raw (INVERT=0) and u_dut_inv (INVERT=1). Expected checksums are
//   hand-computed from the word pairing {byte 2k, byte 2k+1}.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axi_10g_ethernet_0_checksum_stream;

    localparam int DW = 64;

    logic          s_aclk = 1'b0;
    logic          s_areset;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic [15:0]   cfg_seed;
    logic          full;

    logic [15:0]   din_raw, din_inv;
    logic          wr_en_raw, wr_en_inv;
    logic          ovf_raw, ovf_inv;
    logic [15:0]   drops_raw, drops_inv;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            beat_cyc;

    logic [15:0]   cap_raw[$];
    logic [15:0]   cap_inv[$];
    int            cap_cyc[$];

    always #5 s_aclk = ~s_aclk;

    always @(posedge s_aclk) cyc <= cyc + 1;

    axi_10g_ethernet_0_checksum_stream #(
        .DATA_WIDTH(DW), .RESULT_DEPTH(4), .INVERT(1'b0)
    ) u_dut_raw (
        .s_aclk(s_aclk), .s_areset(s_areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .cfg_seed(cfg_seed),
        .din(din_raw), .wr_en(wr_en_raw), .full(full),
        .overflow(ovf_raw), .drop_count(drops_raw)
    );

    axi_10g_ethernet_0_checksum_stream #(
        .DATA_WIDTH(DW), .RESULT_DEPTH(4), .INVERT(1'b1)
    ) u_dut_inv (
        .s_aclk(s_aclk), .s_areset(s_areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .cfg_seed(cfg_seed),
        .din(din_inv), .wr_en(wr_en_inv), .full(full),
        .overflow(ovf_inv), .drop_count(drops_inv)
    );

    // Capture every FIFO write, sampled mid-cycle.
    always @(negedge s_aclk) begin
        if (wr_en_raw) begin
            cap_raw.push_back(din_raw);
            cap_cyc.push_back(cyc);
        end
        if (wr_en_inv) begin
            cap_inv.push_back(din_inv);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] got_raw(input int k);
        return (cap_raw.size() > k) ? cap_raw[k] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] got_inv(input int k);
        return (cap_inv.size() > k) ? cap_inv[k] : 16'hxxxx;
    endfunction

    function automatic int got_cyc(input int k);
        return (cap_cyc.size() > k) ? cap_cyc[k] : -1000;
    endfunction

    task automatic clear_caps();
        cap_raw.delete();
        cap_inv.delete();
        cap_cyc.delete();
    endtask

    // Present one beat for exactly one clock edge; returns at edge + 1.
    task automatic send(input logic [DW-1:0] d, input logic [7:0] k,
                        input logic l, input logic rdy);
        s_axis_tvalid = 1'b1;
        s_axis_tready = rdy;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        @(posedge s_aclk);
        #1;
        beat_cyc      = cyc;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b1;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge s_aclk);
        #1;
    endtask

    task automatic expect_one(input string tag, input logic [15:0] e_raw,
                              input logic [15:0] e_inv);
        idle(8);
        check({tag, "_count"},   32'(cap_raw.size()), 32'd1);
        check({tag, "_raw"},     {16'h0, got_raw(0)}, {16'h0, e_raw});
        check({tag, "_inv"},     {16'h0, got_inv(0)}, {16'h0, e_inv});
        clear_caps();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_areset      = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        cfg_seed      = 16'h0000;
        full          = 1'b0;
        idle(3);
        check("rst_din",   {16'h0, din_raw},   32'h0);
        check("rst_wr_en", {31'h0, wr_en_raw}, 32'h0);
        check("rst_ovf",   {31'h0, ovf_raw},   32'h0);
        check("rst_drops", {16'h0, drops_raw}, 32'h0);
        s_areset = 1'b0;
        idle(2);

        // Single full beat: 0102+0304+0506+0708 = 1014, latency 4 edges.
        clear_caps();
        send(64'h0807_0605_0403_0201, 8'hFF, 1'b1, 1'b1);
        idle(8);
        check("single_latency", 32'(got_cyc(0) - beat_cyc), 32'd4);
        check("single_count",   32'(cap_raw.size()), 32'd1);
        check("single_raw",     {16'h0, got_raw(0)}, 32'h1014);
        check("single_inv",     {16'h0, got_inv(0)}, 32'hEFEB);
        clear_caps();

        // Odd tail: 0102 + 0300.
        send(64'h0000_0000_0003_0201, 8'h07, 1'b1, 1'b1);
        expect_one("odd_tail", 16'h0402, 16'hFBFD);
        cfg_seed = 16'h1000;
        send(64'h0000_0000_0003_0201, 8'h07, 1'b1, 1'b1);
        expect_one("odd_seed", 16'h1402, 16'hEBFD);
        cfg_seed = 16'h0000;

        // tkeep=0 with tlast closes an empty frame.
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, 1'b1);
        expect_one("keep_zero", 16'h0000, 16'hFFFF);

        // Carry fold: 0x7FFF8 -> 0xFFFF.
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b1);
        expect_one("carry", 16'hFFFF, 16'h0000);

        // Unqualified beat ignored, then 8 back-to-back single-beat frames.
        send(64'h0000_0000_0000_5555, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            send({48'h0, 16'(16'h0101 * (k + 1))}, 8'hFF, 1'b1, 1'b1);
        end
        idle(10);
        check("tput_count", 32'(cap_raw.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("tput_raw%0d", k), {16'h0, got_raw(k)},
                  {16'h0, 16'(16'h0101 * (k + 1))});
            check($sformatf("tput_inv%0d", k), {16'h0, got_inv(k)},
                  {16'h0, ~16'(16'h0101 * (k + 1))});
            check($sformatf("tput_cyc%0d", k), 32'(got_cyc(k) - got_cyc(0)), 32'(k));
        end
        clear_caps();

        // Back-pressure: 5 results into a 4-entry queue, last one dropped.
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send({56'h0, 8'(k + 1)}, 8'hFF, 1'b1, 1'b1);
        end
        idle(8);
        check("bp_no_write", 32'(cap_raw.size()), 32'd0);
        check("bp_ovf_raw",  {31'h0, ovf_raw},    32'h1);
        check("bp_drops_raw",{16'h0, drops_raw},  32'h1);
        check("bp_ovf_inv",  {31'h0, ovf_inv},    32'h1);
        check("bp_drops_inv",{16'h0, drops_inv},  32'h1);
        full = 1'b0;
        idle(8);
        check("bp_count", 32'(cap_raw.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_raw%0d", k), {16'h0, got_raw(k)},
                  {16'h0, 16'((k + 1) << 8)});
            check($sformatf("bp_cyc%0d", k), 32'(got_cyc(k) - got_cyc(0)), 32'(k));
        end
        clear_caps();

        // Async reset in the middle of a 3-beat frame.
        send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 1'b1);
        #2;
        s_areset = 1'b1;
        #1;
        check("arst_din",   {16'h0, din_raw},   32'h0);
        check("arst_wr_en", {31'h0, wr_en_raw}, 32'h0);
        check("arst_ovf",   {31'h0, ovf_raw},   32'h0);
        check("arst_drops", {16'h0, drops_raw}, 32'h0);
        idle(2);
        s_areset = 1'b0;
        idle(1);
        clear_caps();
        send(64'h0807_0605_0403_0201, 8'hFF, 1'b1, 1'b1);
        expect_one("post_rst", 16'h1014, 16'hEFEB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
